// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and an LSU port onto a single
// request/ack memory interface. LSU has priority, but after MAX_LSU_RUN
// consecutive LSU grants with fetch waiting, fetch gets the next slot.
// A BUSY access that sees no ack for TIMEOUT cycles is aborted, completes
// with zero read data and raises a sticky error flag.
module mem_arbiter #(
   parameter int MAX_LSU_RUN = 2,
   parameter int TIMEOUT     = 15
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic        o_if_gnt,
   output logic        o_if_done,
   output logic [31:0] o_if_rdata,
   input  logic        i_ls_req,
   input  logic        i_ls_wren,
   input  logic [31:0] i_ls_addr,
   input  logic [31:0] i_ls_wdata,
   input  logic [3:0]  i_ls_bmask,
   output logic        o_ls_gnt,
   output logic        o_ls_done,
   output logic [31:0] o_ls_rdata,
   output logic        o_mem_req,
   output logic        o_mem_wren,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_bmask,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata,
   output logic        o_err_timeout
);

   localparam int RUN_W = (MAX_LSU_RUN < 2) ? 1 : $clog2(MAX_LSU_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_LSU_RUN);
   localparam logic [3:0]       TMO_LAST = 4'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [RUN_W-1:0] run_cnt_reg;
   logic [3:0]       tmo_cnt_reg;
   logic             if_done_reg;
   logic             ls_done_reg;
   logic             ls_wins;
   logic             busy;
   logic             tmo_hit;

   // LSU wins unless fetch is waiting and the LSU has used up its run
   assign ls_wins = i_ls_req && !(i_if_req && (run_cnt_reg == RUN_MAX));
   assign busy    = (state_reg != IDLE);
   // This BUSY cycle is the TIMEOUT-th without ack; a coincident ack wins
   assign tmo_hit = busy && !i_mem_ack && (tmo_cnt_reg == TMO_LAST);

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: grant out of IDLE, leave BUSY on ack or timeout
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (o_ls_gnt) begin
               state_next = BUSY_LS;
            end else if (o_if_gnt) begin
               state_next = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_LS: begin
            if (i_mem_ack || tmo_hit) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs: combinational grants in IDLE, memory request in every BUSY cycle
   always_comb begin
      o_ls_gnt  = 1'b0;
      o_if_gnt  = 1'b0;
      o_mem_req = busy;
      if ((state_reg == IDLE) && !i_reset) begin
         o_ls_gnt = ls_wins;
         o_if_gnt = i_if_req && !ls_wins;
      end
   end

   assign o_if_done = if_done_reg;
   assign o_ls_done = ls_done_reg;

   // Datapath: latch the granted request, capture read data, track run and timeout
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_mem_wren    <= 1'b0;
         o_mem_addr    <= '0;
         o_mem_wdata   <= '0;
         o_mem_bmask   <= '0;
         o_if_rdata    <= '0;
         o_ls_rdata    <= '0;
         run_cnt_reg   <= '0;
         tmo_cnt_reg   <= '0;
         o_err_timeout <= 1'b0;
         if_done_reg   <= 1'b0;
         ls_done_reg   <= 1'b0;
      end else begin
         if_done_reg <= 1'b0;
         ls_done_reg <= 1'b0;
         if (state_reg == IDLE) begin
            tmo_cnt_reg <= '0;
            if (o_ls_gnt) begin
               o_mem_wren  <= i_ls_wren;
               o_mem_addr  <= i_ls_addr;
               o_mem_wdata <= i_ls_wdata;
               o_mem_bmask <= i_ls_bmask;
               if (!i_if_req) begin
                  run_cnt_reg <= '0;
               end else if (run_cnt_reg != RUN_MAX) begin
                  run_cnt_reg <= run_cnt_reg + 1'b1;
               end
            end else if (o_if_gnt) begin
               o_mem_wren  <= 1'b0;
               o_mem_addr  <= i_if_addr;
               o_mem_wdata <= '0;
               o_mem_bmask <= 4'hF;
               run_cnt_reg <= '0;
            end else if (!i_if_req) begin
               run_cnt_reg <= '0;
            end
         end else if (i_mem_ack) begin
            if (state_reg == BUSY_IF) begin
               if_done_reg <= 1'b1;
               o_if_rdata  <= i_mem_rdata;
            end else begin
               ls_done_reg <= 1'b1;
               if (!o_mem_wren) begin
                  o_ls_rdata <= i_mem_rdata;
               end
            end
         end else if (tmo_hit) begin
            o_err_timeout <= 1'b1;
            if (state_reg == BUSY_IF) begin
               if_done_reg <= 1'b1;
               o_if_rdata  <= '0;
            end else begin
               ls_done_reg <= 1'b1;
               o_ls_rdata  <= '0;
            end
         end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model (owner / cycles waited /
// run length) predicts every output each cycle; directed scenarios add
// hand-computed literal expectations.
module tb_mem_arbiter;

   localparam int MAX_LSU_RUN = 2;
   localparam int TIMEOUT     = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_done;
   logic [31:0] if_rdata;
   logic        ls_req, ls_wren;
   logic [31:0] ls_addr, ls_wdata;
   logic [3:0]  ls_bmask;
   logic        ls_gnt, ls_done;
   logic [31:0] ls_rdata;
   logic        mem_req, mem_wren;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_bmask;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        err_timeout;

   mem_arbiter #(.MAX_LSU_RUN(MAX_LSU_RUN), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_if_req(if_req), .i_if_addr(if_addr),
      .o_if_gnt(if_gnt), .o_if_done(if_done), .o_if_rdata(if_rdata),
      .i_ls_req(ls_req), .i_ls_wren(ls_wren), .i_ls_addr(ls_addr),
      .i_ls_wdata(ls_wdata), .i_ls_bmask(ls_bmask),
      .o_ls_gnt(ls_gnt), .o_ls_done(ls_done), .o_ls_rdata(ls_rdata),
      .o_mem_req(mem_req), .o_mem_wren(mem_wren), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
      .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
      .o_err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   bit chk_en = 1'b0;

   // Model: owner 0 = nobody, 1 = fetch, 2 = LSU
   int          m_own   = 0;
   int          m_wait  = 0;
   int          m_run   = 0;
   int          m_done  = 0;
   logic [31:0] m_rd_if = '0;
   logic [31:0] m_rd_ls = '0;
   logic        m_err   = 1'b0;
   logic [31:0] m_addr  = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_bmask = '0;
   logic        m_wren  = 1'b0;

   logic e_ls_gnt, e_if_gnt;
   assign e_ls_gnt = !rst && (m_own == 0) && ls_req && !(if_req && (m_run == MAX_LSU_RUN));
   assign e_if_gnt = !rst && (m_own == 0) && if_req && !e_ls_gnt;

   // Directed-scenario observations
   int q_order[$];
   int if_gnt_cyc  = -1;
   int if_done_cyc = -1;
   int busy_cnt    = 0;
   bit ls_done_seen = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cycle, act, exp);
      end
   endtask

   always @(posedge clk) cycle <= cycle + 1;

   // Model advance
   always @(posedge clk) begin
      if (rst) begin
         m_own <= 0; m_wait <= 0; m_run <= 0; m_done <= 0;
         m_rd_if <= '0; m_rd_ls <= '0; m_err <= 1'b0;
         m_addr <= '0; m_wdata <= '0; m_bmask <= '0; m_wren <= 1'b0;
      end else begin
         m_done <= 0;
         if (m_own == 0) begin
            m_wait <= 0;
            if (e_ls_gnt) begin
               m_own <= 2;
               m_addr <= ls_addr; m_wdata <= ls_wdata; m_bmask <= ls_bmask; m_wren <= ls_wren;
               m_run <= if_req ? ((m_run < MAX_LSU_RUN) ? m_run + 1 : MAX_LSU_RUN) : 0;
            end else if (e_if_gnt) begin
               m_own <= 1;
               m_addr <= if_addr; m_wdata <= '0; m_bmask <= 4'hF; m_wren <= 1'b0;
               m_run <= 0;
            end else if (!if_req) begin
               m_run <= 0;
            end
         end else if (mem_ack) begin
            m_done <= m_own;
            m_own  <= 0;
            if (m_own == 1) m_rd_if <= mem_rdata;
            else if (!m_wren) m_rd_ls <= mem_rdata;
         end else if (m_wait + 1 == TIMEOUT) begin
            m_done <= m_own;
            m_own  <= 0;
            m_err  <= 1'b1;
            if (m_own == 1) m_rd_if <= '0;
            else m_rd_ls <= '0;
         end else begin
            m_wait <= m_wait + 1;
         end
      end
   end

   // Compare process: all outputs every cycle, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("if_gnt",  {31'b0, if_gnt},  {31'b0, e_if_gnt});
         chk("ls_gnt",  {31'b0, ls_gnt},  {31'b0, e_ls_gnt});
         chk("if_done", {31'b0, if_done}, {31'b0, m_done == 1});
         chk("ls_done", {31'b0, ls_done}, {31'b0, m_done == 2});
         chk("mem_req", {31'b0, mem_req}, {31'b0, m_own != 0});
         chk("if_rdata", if_rdata, m_rd_if);
         chk("ls_rdata", ls_rdata, m_rd_ls);
         chk("err_timeout", {31'b0, err_timeout}, {31'b0, m_err});
         if (m_own != 0) begin
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_bmask", {28'b0, mem_bmask}, {28'b0, m_bmask});
            chk("mem_wren",  {31'b0, mem_wren},  {31'b0, m_wren});
         end
         if (ls_gnt) q_order.push_back(2);
         if (if_gnt) begin q_order.push_back(1); if_gnt_cyc = cycle; end
         if (if_done) if_done_cyc = cycle;
         if (mem_req) busy_cnt++;
         if (ls_done) ls_done_seen = 1'b1;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int exp_order[6] = '{2, 2, 1, 2, 2, 1};

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_wren = 1'b0; ls_addr = '0; ls_wdata = '0; ls_bmask = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      cyc(1);
      chk_en = 1'b1;
      cyc(2);
      chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
      chk("reset_mem_bmask", {28'b0, mem_bmask}, 32'd0);
      rst = 1'b0;
      cyc(1);

      // Fetch only, immediate ack
      if_req = 1'b1; if_addr = 32'h100; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      cyc(1);
      if_req = 1'b0;
      cyc(3);
      chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
      chk("fetch_latency", if_done_cyc - if_gnt_cyc, 32'd2);

      // Contention with immediate ack
      q_order.delete();
      ls_req = 1'b1; ls_wren = 1'b0; ls_addr = 32'h40; ls_bmask = 4'hF;
      if_req = 1'b1; if_addr = 32'h104; mem_rdata = 32'hA5A5A5A5;
      cyc(12);
      ls_req = 1'b0; if_req = 1'b0;
      cyc(2);
      chk("order_len_ge6", {31'b0, q_order.size() >= 6}, 32'd1);
      for (int k = 0; k < 6; k++) begin
         if (k < q_order.size()) chk($sformatf("order[%0d]", k), q_order[k], exp_order[k]);
      end

      // LSU write, ack in the third BUSY cycle
      mem_ack = 1'b0; mem_rdata = 32'hFFFF0000;
      ls_req = 1'b1; ls_wren = 1'b1; ls_addr = 32'h2000; ls_wdata = 32'h12345678; ls_bmask = 4'b0011;
      cyc(1);
      ls_req = 1'b0; ls_wren = 1'b0;
      cyc(2);
      mem_ack = 1'b1;
      cyc(1);
      mem_ack = 1'b0;
      cyc(2);
      chk("write_keeps_ls_rdata", ls_rdata, 32'hA5A5A5A5);

      // Timeout on a fetch
      busy_cnt = 0;
      if_req = 1'b1; if_addr = 32'h300;
      cyc(1);
      if_req = 1'b0;
      cyc(20);
      chk("timeout_err", {31'b0, err_timeout}, 32'd1);
      chk("timeout_rdata", if_rdata, 32'd0);
      chk("timeout_busy_cycles", busy_cnt, 32'd15);

      // Ack on the 15th BUSY cycle wins over timeout
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("err_cleared", {31'b0, err_timeout}, 32'd0);
      busy_cnt = 0;
      if_req = 1'b1; if_addr = 32'h400; mem_rdata = 32'h0BADF00D;
      cyc(1);
      if_req = 1'b0;
      cyc(14);
      mem_ack = 1'b1;
      cyc(1);
      mem_ack = 1'b0;
      cyc(2);
      chk("late_ack_err", {31'b0, err_timeout}, 32'd0);
      chk("late_ack_rdata", if_rdata, 32'h0BADF00D);
      chk("late_ack_busy_cycles", busy_cnt, 32'd15);

      // Reset in BUSY_LS aborts without done
      ls_req = 1'b1; ls_wren = 1'b0; ls_addr = 32'h500; ls_bmask = 4'hF;
      cyc(1);
      ls_req = 1'b0;
      ls_done_seen = 1'b0;
      cyc(2);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
      chk("abort_mem_addr", mem_addr, 32'd0);
      chk("abort_ls_rdata", ls_rdata, 32'd0);
      cyc(3);
      chk("abort_no_done", {31'b0, ls_done_seen}, 32'd0);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
